// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// A flush request starts a sweep FSM that invalidates one entry per cycle.
module btb_predictor #(
    parameter int BUS_WIDTH = 32,
    parameter int IDX_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] pc_if,
    output logic                 bp_taken_if,
    output logic [BUS_WIDTH-1:0] bp_target_if,
    input  logic                 upd_en,
    input  logic [BUS_WIDTH-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [BUS_WIDTH-1:0] upd_target,
    input  logic                 upd_kill,
    input  logic                 flush_req,
    output logic                 flush_busy
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = BUS_WIDTH - IDX_BITS - 2;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state, state_nxt;
    logic [IDX_BITS-1:0]  sweep_cnt, sweep_nxt;
    logic                 sweep_clr;

    logic [ENTRIES-1:0]   valid;
    logic [TAG_W-1:0]     tag    [ENTRIES];
    logic [BUS_WIDTH-1:0] target [ENTRIES];
    logic [1:0]           ctr    [ENTRIES];

    // Lookup path
    logic [IDX_BITS-1:0]  lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic                 lk_hit;

    assign lk_idx       = pc_if[IDX_BITS+1:2];
    assign lk_tag       = pc_if[BUS_WIDTH-1:IDX_BITS+2];
    assign lk_hit       = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign flush_busy   = (state == SWEEP);
    assign bp_taken_if  = lk_hit && ctr[lk_idx][1] && !flush_busy;
    assign bp_target_if = bp_taken_if ? target[lk_idx] : '0;

    // Update path; a pending flush or an active sweep swallows the update
    logic [IDX_BITS-1:0]  up_idx;
    logic [TAG_W-1:0]     up_tag;
    logic                 up_match, up_hit, up_act;
    logic                 up_kill, up_inc, up_dec, up_alloc;

    assign up_idx   = upd_pc[IDX_BITS+1:2];
    assign up_tag   = upd_pc[BUS_WIDTH-1:IDX_BITS+2];
    assign up_match = (tag[up_idx] == up_tag);
    assign up_hit   = valid[up_idx] && up_match;
    assign up_act   = upd_en && (state == IDLE) && !flush_req;
    assign up_kill  = up_act && upd_kill && up_match;
    assign up_inc   = up_act && !upd_kill && up_hit && upd_taken;
    assign up_dec   = up_act && !upd_kill && up_hit && !upd_taken;
    assign up_alloc = up_act && !upd_kill && !up_hit && upd_taken;

    logic unused_lsbs;
    assign unused_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_cnt;
        sweep_clr = 1'b0;
        case (state)
            IDLE: if (flush_req) state_nxt = SWEEP;
            SWEEP: begin
                sweep_clr = 1'b1;
                sweep_nxt = sweep_cnt + 1'b1;
                if (sweep_cnt == '1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            valid     <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
            if (sweep_clr) valid[sweep_cnt] <= 1'b0;
            if (up_kill)   valid[up_idx]    <= 1'b0;
            if (up_alloc)  valid[up_idx]    <= 1'b1;
        end
    end

    // Payload carries no reset: it is only observed through valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (up_alloc) begin
                tag[up_idx]    <= up_tag;
                target[up_idx] <= upd_target;
                ctr[up_idx]    <= 2'b10;
            end
            if (up_inc) begin
                target[up_idx] <= upd_target;
                if (ctr[up_idx] != 2'b11) ctr[up_idx] <= ctr[up_idx] + 2'd1;
            end
            if (up_dec && ctr[up_idx] != 2'b00) ctr[up_idx] <= ctr[up_idx] - 2'd1;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed + randomized check of btb_predictor against a table-level reference model.
module tb_btb_predictor;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] pc_if = 0, upd_pc = 0, upd_target = 0;
    logic        upd_en = 0, upd_taken = 0, upd_kill = 0, flush_req = 0;
    logic        bp_taken_if, flush_busy;
    logic [31:0] bp_target_if;

    int total = 0, bad = 0;
    bit chk_en = 0;

    btb_predictor #(.BUS_WIDTH(32), .IDX_BITS(4)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .bp_taken_if(bp_taken_if),
        .bp_target_if(bp_target_if), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_kill(upd_kill),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    // Reference model: the table as plain arrays, flush as a busy countdown
    bit        m_valid [16];
    bit [25:0] m_tag   [16];
    bit [31:0] m_tgt   [16];
    int        m_ctr   [16];
    int        m_busy = 0;

    function automatic void mpred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int i;
        i  = int'(pc[5:2]);
        t  = m_valid[i] && m_tag[i] == pc[31:6] && m_ctr[i] >= 2 && m_busy == 0;
        tg = t ? m_tgt[i] : 32'h0;
    endfunction

    always @(posedge clk) begin
        int i;
        bit hit;
        i   = int'(upd_pc[5:2]);
        hit = m_valid[i] && m_tag[i] == upd_pc[31:6];
        if (rst) begin
            foreach (m_valid[k]) m_valid[k] = 0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end else if (flush_req) begin
            foreach (m_valid[k]) m_valid[k] = 0;
            m_busy = 16;
        end else if (upd_en) begin
            if (upd_kill) begin
                if (hit) m_valid[i] = 0;
            end else if (hit) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = upd_pc[31:6];
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit          et;
        logic [31:0] eg;
        if (chk_en) begin
            mpred(pc_if, et, eg);
            chk("model_taken", {31'h0, bp_taken_if}, {31'h0, et});
            chk("model_target", bp_target_if, eg);
            chk("model_busy", {31'h0, flush_busy}, {31'h0, m_busy > 0});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        rst = 0; upd_en = 0; upd_kill = 0; flush_req = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        upd_en = 1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_kill = 0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        pc_if = pc; #1;
        chk({name, "_taken"}, {31'h0, bp_taken_if}, {31'h0, t});
        chk({name, "_target"}, bp_target_if, tg);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            upd(32'h1000 + 32'(i) * 4, 1, 32'h8000 + 32'(i) * 16);
            tick();
        end
    endtask

    initial begin
        rst = 1;
        tick();
        chk_en = 1;
        look("reset", 32'h100, 0, 0);
        chk("reset_busy", {31'h0, flush_busy}, 0);

        upd(32'h100, 1, 32'h200); tick();
        look("alloc_hit", 32'h100, 1, 32'h200);
        look("alias_miss", 32'h140, 0, 0);

        pc_if = 32'h100;
        upd(32'h100, 0, 0); tick();
        look("dec1", 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) begin upd(32'h100, 0, 0); tick(); end
        upd(32'h100, 1, 32'h200); tick();
        look("inc_from0", 32'h100, 0, 0);
        upd(32'h100, 1, 32'h200); tick();
        look("inc_to2", 32'h100, 1, 32'h200);

        upd(32'h100, 1, 32'h240); upd_kill = 1; tick();
        look("kill", 32'h100, 0, 0);

        fill_all();
        look("filled", 32'h1008, 1, 32'h8020);
        flush_req = 1; tick();
        for (int c = 0; c < 16; c++) begin
            chk("sweep_busy", {31'h0, flush_busy}, 1);
            upd(32'h1000 + 32'(c) * 4, 1, 32'hDEAD0000);
            if (c == 3) flush_req = 1;
            look("sweep_pred", 32'h1000 + 32'(c) * 4, 0, 0);
            tick();
        end
        chk("sweep_done", {31'h0, flush_busy}, 0);
        for (int i = 0; i < 16; i++) look("after_sweep", 32'h1000 + 32'(i) * 4, 0, 0);

        fill_all();
        flush_req = 1; tick();
        for (int c = 0; c < 5; c++) tick();
        rst = 1; tick();
        chk("rst_abort_busy", {31'h0, flush_busy}, 0);
        for (int i = 0; i < 16; i++) look("rst_abort", 32'h1000 + 32'(i) * 4, 0, 0);
        upd(32'h100, 1, 32'h300); tick();
        look("post_rst", 32'h100, 1, 32'h300);

        rst = 1; flush_req = 1; upd(32'h180, 1, 32'h500); tick();
        chk("rst_dom_busy", {31'h0, flush_busy}, 0);
        look("rst_dom", 32'h180, 0, 0);

        flush_req = 1; upd(32'h180, 1, 32'h500); tick();
        chk("flush_upd_busy", {31'h0, flush_busy}, 1);
        for (int c = 0; c < 16; c++) tick();
        look("flush_upd", 32'h180, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            pc_if      = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            upd_pc     = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            upd_en     = ($urandom_range(0, 99) < 60);
            upd_taken  = ($urandom_range(0, 99) < 60);
            upd_kill   = ($urandom_range(0, 99) < 8);
            upd_target = $urandom & 32'hFFFF_FFFC;
            flush_req  = ($urandom_range(0, 999) < 8);
            rst        = ($urandom_range(0, 999) < 4);
            @(posedge clk); #1;
        end
        rst = 0; upd_en = 0; flush_req = 0; upd_kill = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
